// File: rtl/xcorr_peak_detect_if.sv
// Stream bundle between the correlation IFFT and the peak detector.
// The master drives samples and the slave returns magnitudes and per-frame results.
interface xcorr_peak_detect_if #(
  parameter int IDX_W = 10,
  parameter int MAG_W = 32,
  parameter int EXP_W = 5
);
  logic                ival;
  logic signed [15:0]  idata_i;
  logic signed [15:0]  idata_q;
  logic [EXP_W-1:0]    iexp;
  logic                ieop;
  logic [MAG_W-1:0]    thresh;

  logic                mag_val;
  logic [MAG_W-1:0]    mag_out;
  logic                res_val;
  logic [IDX_W-1:0]    res_idx;
  logic [MAG_W-1:0]    res_mag;
  logic [EXP_W-1:0]    res_exp;
  logic                res_det;
  logic                res_err;

  modport master (
    output ival, idata_i, idata_q, iexp, ieop, thresh,
    input  mag_val, mag_out, res_val, res_idx, res_mag, res_exp, res_det, res_err
  );

  modport slave (
    input  ival, idata_i, idata_q, iexp, ieop, thresh,
    output mag_val, mag_out, res_val, res_idx, res_mag, res_exp, res_det, res_err
  );
endinterface

// File: rtl/xcorr_peak_detect.sv
// Per-sample |x|^2 (3-stage pipe) with frame max/index tracking and a one-cycle result
// pulse 4 cycles after the eop sample; no backpressure, every valid sample is consumed.
module xcorr_peak_detect #(
  parameter int IDX_W = 10,
  parameter int MAG_W = 32,
  parameter int EXP_W = 5
) (
  input  logic clk,
  input  logic rst,
  xcorr_peak_detect_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  logic               s1_vld, s1_eop;
  logic signed [15:0] s1_i, s1_q;
  logic [EXP_W-1:0]   s1_exp;
  logic [MAG_W-1:0]   s1_thr;

  logic               s2_vld, s2_eop;
  logic [31:0]        s2_ii, s2_qq;
  logic [EXP_W-1:0]   s2_exp;
  logic [MAG_W-1:0]   s2_thr;

  logic               s3_vld, s3_eop;
  logic [MAG_W-1:0]   s3_mag;
  logic [EXP_W-1:0]   s3_exp;
  logic [MAG_W-1:0]   s3_thr;

  logic signed [31:0] ii_p, qq_p;
  logic [MAG_W-1:0]   mag_sum;

  assign ii_p    = 32'(s1_i) * 32'(s1_i);
  assign qq_p    = 32'(s1_q) * 32'(s1_q);
  assign mag_sum = MAG_W'(s2_ii) + MAG_W'(s2_qq);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0; s1_eop <= 1'b0; s1_i <= '0; s1_q <= '0; s1_exp <= '0; s1_thr <= '0;
      s2_vld <= 1'b0; s2_eop <= 1'b0; s2_ii <= '0; s2_qq <= '0; s2_exp <= '0; s2_thr <= '0;
      s3_vld <= 1'b0; s3_eop <= 1'b0; s3_mag <= '0; s3_exp <= '0; s3_thr <= '0;
    end else begin
      s1_vld <= bus.ival;
      s1_eop <= bus.ival & bus.ieop;
      s1_i   <= bus.idata_i;
      s1_q   <= bus.idata_q;
      s1_exp <= bus.iexp;
      s1_thr <= bus.thresh;

      s2_vld <= s1_vld;
      s2_eop <= s1_eop;
      s2_ii  <= unsigned'(ii_p);
      s2_qq  <= unsigned'(qq_p);
      s2_exp <= s1_exp;
      s2_thr <= s1_thr;

      s3_vld <= s2_vld;
      s3_eop <= s2_eop;
      s3_mag <= mag_sum;
      s3_exp <= s2_exp;
      s3_thr <= s2_thr;
    end
  end

  assign bus.mag_val = s3_vld;
  assign bus.mag_out = s3_mag;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic [MAG_W-1:0]   max_mag;
  logic [IDX_W-1:0]   max_idx;
  logic [EXP_W-1:0]   exp_r;
  logic               err_r;

  logic               first;
  logic               wrap;
  logic               res_val_c;
  logic [MAG_W-1:0]   new_max;
  logic [IDX_W-1:0]   new_idx;
  logic [EXP_W-1:0]   new_exp;
  logic               new_err;

  // DONE is folded: a sample arriving while DONE is treated as the next frame's first sample.
  always_comb begin
    state_nxt = state;
    res_val_c = 1'b0;
    first     = (state != ACC);
    wrap      = s3_vld && !s3_eop && (cnt == {IDX_W{1'b1}});
    new_max   = max_mag;
    new_idx   = max_idx;
    new_exp   = exp_r;
    new_err   = err_r;

    if (state == DONE) begin
      res_val_c = 1'b1;
      state_nxt = IDLE;
    end

    if (first) begin
      new_max = s3_mag;
      new_idx = '0;
      new_exp = s3_exp;
      new_err = wrap;
    end else begin
      if (s3_mag > max_mag) begin
        new_max = s3_mag;
        new_idx = cnt;
      end
      new_err = err_r | wrap | (s3_exp != exp_r);
    end

    if (s3_vld) state_nxt = s3_eop ? DONE : ACC;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      max_mag     <= '0;
      max_idx     <= '0;
      exp_r       <= '0;
      err_r       <= 1'b0;
      bus.res_idx <= '0;
      bus.res_mag <= '0;
      bus.res_exp <= '0;
      bus.res_det <= 1'b0;
      bus.res_err <= 1'b0;
    end else if (s3_vld) begin
      cnt     <= s3_eop ? '0 : cnt + 1'b1;
      max_mag <= new_max;
      max_idx <= new_idx;
      exp_r   <= new_exp;
      err_r   <= new_err;
      if (s3_eop) begin
        bus.res_idx <= new_idx;
        bus.res_mag <= new_max;
        bus.res_exp <= new_exp;
        bus.res_det <= (new_max >= s3_thr);
        bus.res_err <= new_err;
      end
    end
  end

  assign bus.res_val = res_val_c;

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// Randomized scoreboard bench for xcorr_peak_detect: frames are described as sample lists,
// expected magnitudes/results come from whole-frame arithmetic and are checked by a monitor.
module tb_xcorr_peak_detect;
  localparam int IDX_W = 10;
  localparam int MAG_W = 32;
  localparam int EXP_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xcorr_peak_detect_if #(.IDX_W(IDX_W), .MAG_W(MAG_W), .EXP_W(EXP_W)) bus ();

  xcorr_peak_detect #(.IDX_W(IDX_W), .MAG_W(MAG_W), .EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint mag; int cyc; } mag_e_t;
  typedef struct { longint idx; longint mag; longint exp; longint det; longint err; int cyc; } res_e_t;

  mag_e_t mag_q[$];
  res_e_t res_q[$];
  mag_e_t me;
  res_e_t re;
  int fr_i[$];
  int fr_q[$];
  int fr_e[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mag_val === 1'b1) begin
        if (mag_q.size() == 0) chk("mag_unexpected", 1, 0);
        else begin
          me = mag_q.pop_front();
          chk("mag_out", bus.mag_out, me.mag);
          chk("mag_latency", cyc, me.cyc);
        end
      end
      if (bus.res_val === 1'b1) begin
        if (res_q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          re = res_q.pop_front();
          chk("res_idx", bus.res_idx, re.idx);
          chk("res_mag", bus.res_mag, re.mag);
          chk("res_exp", bus.res_exp, re.exp);
          chk("res_det", bus.res_det, re.det);
          chk("res_err", bus.res_err, re.err);
          chk("res_latency", cyc, re.cyc);
        end
      end
    end
  end

  task automatic drive(input logic v, input int i, input int q, input int e,
                       input logic eop, input longint thr);
    @(posedge clk);
    #1;
    bus.ival    = v;
    bus.idata_i = 16'(i);
    bus.idata_q = 16'(q);
    bus.iexp    = EXP_W'(e);
    bus.ieop    = eop;
    bus.thresh  = 32'(thr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic set_rand(input int n, input int amp, input int e);
    fr_i.delete(); fr_q.delete(); fr_e.delete();
    for (int k = 0; k < n; k++) begin
      fr_i.push_back(int'($urandom_range(2 * amp)) - amp);
      fr_q.push_back(int'($urandom_range(2 * amp)) - amp);
      fr_e.push_back(e);
    end
  endtask

  task automatic set_impulse(input int n, input int pos, input int val, input int e);
    set_rand(n, 0, e);
    fr_i[pos] = val;
  endtask

  // Sends the current frame; gaps (with junk ieop) are inserted at random.
  task automatic run_frame(input int gap_pct, input longint thr);
    int     n;
    int     gaps;
    int     bidx;
    longint best;
    longint m;
    logic   err;
    n    = fr_i.size();
    best = -1;
    bidx = 0;
    err  = 1'b0;
    for (int k = 0; k < n; k++) begin
      gaps = 0;
      while (gaps < 3 && int'($urandom_range(99)) < gap_pct) begin
        drive(1'b0, int'($urandom), int'($urandom), int'($urandom_range(31)), 1'($urandom), longint'($urandom));
        gaps++;
      end
      drive(1'b1, fr_i[k], fr_q[k], fr_e[k], (k == n - 1), (k == n - 1) ? thr : longint'($urandom));
      m = longint'(fr_i[k]) * fr_i[k] + longint'(fr_q[k]) * fr_q[k];
      mag_q.push_back('{m, cyc + 3});
      if (m > best) begin
        best = m;
        bidx = k % (1 << IDX_W);
      end
      if (fr_e[k] != fr_e[0]) err = 1'b1;
    end
    if (n > (1 << IDX_W)) err = 1'b1;
    res_q.push_back('{longint'(bidx), best, longint'(fr_e[0]), longint'(best >= thr), longint'(err), cyc + 4});
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_mag_val", bus.mag_val, 0);
    chk("rst_mag_out", bus.mag_out, 0);
    chk("rst_res_val", bus.res_val, 0);
    chk("rst_res_idx", bus.res_idx, 0);
    chk("rst_res_mag", bus.res_mag, 0);
    chk("rst_res_exp", bus.res_exp, 0);
    chk("rst_res_det", bus.res_det, 0);
    chk("rst_res_err", bus.res_err, 0);
  endtask

  initial begin
    int n, amp, e;
    bus.ival = 1'b0; bus.idata_i = '0; bus.idata_q = '0;
    bus.iexp = '0; bus.ieop = 1'b0; bus.thresh = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs();

    // impulse at index 5
    set_impulse(8, 5, 1000, 3);
    run_frame(0, 0);
    idle(2);

    // equal peaks: earliest index wins
    set_rand(8, 50, 12);
    fr_i[2] = 200; fr_q[2] = 200;
    fr_i[6] = 200; fr_q[6] = 200;
    run_frame(30, longint'($urandom));
    idle(1);

    // full-scale negative sample
    set_rand(4, 1000, 21);
    fr_i[0] = -32768; fr_q[0] = -32768;
    run_frame(0, 64'h8000_0000);

    // threshold boundary, back to back
    set_impulse(6, 1, 1000, 4);
    run_frame(0, 1000000);
    run_frame(0, 1000001);
    idle(3);

    // frame A clean, frame B with exponent change at index 3, no gap between
    set_rand(10, 3000, 7);
    run_frame(40, 5000000);
    set_rand(12, 3000, 9);
    for (int k = 3; k < 12; k++) fr_e[k] = 10;
    run_frame(40, 1000);

    // single-sample frames back to back
    set_rand(1, 20000, 2);
    run_frame(0, 100);
    set_rand(1, 20000, 30);
    run_frame(0, 64'hFFFF_FFFF);

    for (int f = 0; f < 15; f++) begin
      n   = int'($urandom_range(1, 20));
      amp = int'($urandom_range(1, 32767));
      e   = int'($urandom_range(31));
      set_rand(n, amp, e);
      if ($urandom_range(3) == 0) fr_e[n - 1] = (e + 1) % 32;
      run_frame(int'($urandom_range(50)), longint'($urandom_range(0, amp * amp)));
    end

    // index counter wrap
    set_rand(1030, 100, 1);
    run_frame(0, 0);
    idle(8);

    // reset at index 4 of a frame discards it
    set_rand(8, 500, 5);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, fr_i[k], fr_q[k], fr_e[k], 1'b0, 0);
      mag_q.push_back('{longint'(fr_i[k]) * fr_i[k] + longint'(fr_q[k]) * fr_q[k], cyc + 3});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.ival = 1'b1; bus.idata_i = 16'(fr_i[4]); bus.idata_q = 16'(fr_q[4]); bus.ieop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ival = 1'b0;
    mag_q.delete();
    check_reset_outputs();

    set_impulse(5, 2, 700, 6);
    run_frame(20, 1);
    idle(2);

    for (int k = 0; k < 100 && (mag_q.size() != 0 || res_q.size() != 0); k++) @(posedge clk);
    chk("drain_mag_q", mag_q.size(), 0);
    chk("drain_res_q", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
